// File: rtl/cmd_dispatch.sv
// Command execution stage behind the UART wrapper: decodes a 16-bit command against a
// 16x8 register file and returns one response byte per command via send_resp/resp_sent.
module cmd_dispatch #(
  parameter logic [7:0] ACK_BYTE = 8'hA5,
  parameter logic [7:0] NAK_BYTE = 8'hEE,
  parameter int         TIMEOUT  = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_rdy,
  input  logic [15:0] cmd,
  output logic        clr_cmd_rdy,
  output logic        send_resp,
  output logic [7:0]  resp,
  input  logic        resp_sent,
  input  logic [3:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  err_cnt
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;
  // Counter value in the last WAIT cycle; its increment lands on TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, EXEC, RESP, WAIT} state_t;

  state_t        state;
  logic [15:0]   cmd_q;
  logic [CW-1:0] to_cnt;
  logic [7:0]    regs [16];

  wire [3:0] op   = cmd_q[15:12];
  wire [3:0] addr = cmd_q[11:8];
  wire [7:0] data = cmd_q[7:0];

  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_q       <= '0;
      to_cnt      <= '0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      resp        <= '0;
      err_cnt     <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_rdy) begin
            cmd_q       <= cmd;
            clr_cmd_rdy <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            4'h1: begin regs[addr] <= data;         resp <= ACK_BYTE; end
            4'h2: begin                             resp <= regs[addr]; end
            4'h3: begin regs[addr] <= regs[addr] + 8'd1; resp <= ACK_BYTE; end
            4'h4: begin
              for (int i = 0; i < 16; i++) regs[i] <= '0;
              resp <= ACK_BYTE;
            end
            default: begin
              resp <= NAK_BYTE;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          endcase
          send_resp <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (resp_sent) begin
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_LAST) begin
              state <= IDLE;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomized bench for cmd_dispatch with a register-file/error-count reference model.
module tb_cmd_dispatch;
  localparam int TIMEOUT = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_rdy = 1'b0;
  logic [15:0] cmd = '0;
  logic        resp_sent = 1'b0;
  logic [3:0]  dbg_addr = '0;
  logic        clr_cmd_rdy, send_resp;
  logic [7:0]  resp, dbg_data, err_cnt;

  cmd_dispatch #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .resp_sent(resp_sent), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] mregs [16];
  int merr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  function automatic void err_inc();
    if (merr < 255) merr++;
  endfunction

  // Reference: apply one command to the model, return the expected response.
  function automatic logic [7:0] model(input logic [15:0] c);
    logic [3:0] a;
    logic [7:0] r;
    a = c[11:8];
    r = 8'hA5;
    case (c[15:12])
      4'h1: mregs[a] = c[7:0];
      4'h2: r = mregs[a];
      4'h3: mregs[a] = 8'((int'(mregs[a]) + 1) % 256);
      4'h4: for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
      default: begin r = 8'hEE; err_inc(); end
    endcase
    return r;
  endfunction

  task automatic wait_chk(input logic [7:0] er);
    chk("wait_send", 32'(send_resp), 0);
    chk("wait_clr", 32'(clr_cmd_rdy), 0);
    chk("resp_stable", 32'(resp), 32'(er));
  endtask

  // Call with cmd_rdy low and block idle; ends resynced to a negedge.
  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk(tag, 32'(dbg_data), 32'(mregs[i]));
    end
    @(negedge clk);
  endtask

  // delay>0: resp_sent pulsed delay cycles after send_resp; 0: withheld (timeout);
  // <0: return in the send_resp cycle, leaving the block in WAIT.
  task automatic run_cmd(input logic [15:0] c, input int delay, input bit hold,
                         input logic [15:0] next_c);
    int n;
    logic [7:0] er;
    n = 0;
    cmd = c;
    cmd_rdy = 1'b1;
    do begin @(negedge clk); n++; end while (!clr_cmd_rdy && n < 8);
    chk("cap_lat", 32'(n), 1);
    cmd_rdy = 1'b0;
    chk("clr_excl", 32'(send_resp), 0);
    er = model(c);
    @(negedge clk);
    chk("clr_pulse", 32'(clr_cmd_rdy), 0);
    chk("send_resp", 32'(send_resp), 1);
    chk("resp", 32'(resp), 32'(er));
    chk("err_cnt", 32'(err_cnt), 32'(merr));
    dbg_addr = c[11:8];
    #1;
    chk("dbg_next", 32'(dbg_data), 32'(mregs[c[11:8]]));
    if (hold) begin cmd = next_c; cmd_rdy = 1'b1; end
    if (delay > 0) begin
      repeat (delay - 1) begin @(negedge clk); wait_chk(er); end
      @(negedge clk);
      wait_chk(er);
      resp_sent = 1'b1;
      @(negedge clk);
      resp_sent = 1'b0;
      chk("idle_clr", 32'(clr_cmd_rdy), 0);
    end else if (delay == 0) begin
      repeat (TIMEOUT - 1) begin @(negedge clk); wait_chk(er); end
      chk("to_early", 32'(err_cnt), 32'(merr));
      @(negedge clk);
      err_inc();
      chk("to_err", 32'(err_cnt), 32'(merr));
      chk("to_clr", 32'(clr_cmd_rdy), 0);
      chk("to_send", 32'(send_resp), 0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c, nc;
    logic [3:0] op;
    int r;
    bit hold;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;

    // Reset state
    @(negedge clk);
    chk("rst_clr", 32'(clr_cmd_rdy), 0);
    chk("rst_send", 32'(send_resp), 0);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_err", 32'(err_cnt), 0);
    rst_n = 1'b1;
    check_regs("rst_reg");

    // Basic write, 5-cycle resp_sent
    run_cmd(16'h1342, 5, 0, 16'h0);
    check_regs("wr_reg");

    // Write FF, INC wraps, READ back 00
    run_cmd(16'h17FF, 2, 0, 16'h0);
    run_cmd(16'h3700, 3, 0, 16'h0);
    run_cmd(16'h2700, 1, 0, 16'h0);
    check_regs("wrap_reg");

    // Unknown opcode
    run_cmd(16'hF123, 2, 0, 16'h0);
    check_regs("nak_reg");

    // Fill then CLEAR
    for (int i = 0; i < 16; i++) run_cmd({4'h1, 4'(i), 8'(i + 1)}, 1, 0, 16'h0);
    check_regs("fill_reg");
    run_cmd(16'h4ABC, 2, 0, 16'h0);
    check_regs("clr_reg");

    // Timeout with next command held during WAIT
    run_cmd(16'h1A77, 0, 1, 16'h2A00);
    run_cmd(16'h2A00, 2, 0, 16'h0);

    // Reset during WAIT
    run_cmd(16'h1255, 2, 0, 16'h0);
    run_cmd(16'h2200, -1, 0, 16'h0);
    @(negedge clk);
    rst_n = 1'b0;
    dbg_addr = 4'h2;
    #1;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    merr = 0;
    chk("mrst_clr", 32'(clr_cmd_rdy), 0);
    chk("mrst_send", 32'(send_resp), 0);
    chk("mrst_resp", 32'(resp), 0);
    chk("mrst_err", 32'(err_cnt), 0);
    chk("mrst_reg2", 32'(dbg_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_send", 32'(send_resp), 0);
      chk("post_rst_clr", 32'(clr_cmd_rdy), 0);
    end
    // cmd_rdy held through WAIT is captured only after resp_sent
    run_cmd(16'h1301, 4, 1, 16'h2300);
    run_cmd(16'h2300, 2, 0, 16'h0);
    check_regs("post_rst_reg");

    // Randomized traffic
    hold = 0;
    nc = 16'h0;
    for (int k = 0; k < 80; k++) begin
      r = int'($urandom_range(0, 9));
      op = (r < 8) ? 4'((r % 4) + 1) : 4'($urandom_range(5, 15));
      c = hold ? nc : {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
      r = int'($urandom_range(0, 9));
      op = (r < 8) ? 4'((r % 4) + 1) : 4'($urandom_range(5, 15));
      nc = {op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
      hold = (k != 79) && ($urandom_range(0, 2) == 0);
      run_cmd(c, int'($urandom_range(1, 6)), hold, nc);
    end
    check_regs("rand_reg");

    // err_cnt saturation
    for (int k = 0; k < 260; k++) run_cmd({4'h9, 12'(k)}, 1, 0, 16'h0);
    chk("err_sat", 32'(err_cnt), 32'hFF);
    check_regs("sat_reg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
